// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, presents it to instruction memory, and latches the fetched
// word together with PC+4. Supports load-use stall, branch/jump redirect
// from ID, a HALT opcode that freezes fetch, and fetch/flush counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        halted_o,
  output logic [31:0] fetch_count_o,
  output logic [31:0] flush_count_o
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_seq;
  logic [31:0] jump_target;
  logic        redirect;

  assign pc_seq      = pc + 32'd4;
  assign jump_target = {pc_plus4_o[31:28], instr_o[25:0], 2'b00};
  assign redirect    = jump_i | branch_taken_i;

  assign imem_addr_o = pc;
  assign op_o        = instr_o[31:26];

  // PC, IF/ID register, FSM and counters; priority reset > stall > redirect > halt > fetch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc            <= RESET_PC;
      instr_o       <= '0;
      pc_plus4_o    <= '0;
      valid_o       <= 1'b0;
      halted_o      <= 1'b0;
      state         <= RUN;
      fetch_count_o <= '0;
      flush_count_o <= '0;
    end else if (stall_i) begin
      // everything holds; a concurrent redirect is re-presented later by ID
    end else if (redirect) begin
      pc            <= jump_i ? jump_target : branch_target_i;
      instr_o       <= '0;
      pc_plus4_o    <= '0;
      valid_o       <= 1'b0;
      flush_count_o <= flush_count_o + 32'd1;
    end else if (state == HALT) begin
      instr_o    <= '0;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
    end else begin
      pc            <= pc_seq;
      instr_o       <= imem_data_i;
      pc_plus4_o    <= pc_seq;
      valid_o       <= 1'b1;
      fetch_count_o <= fetch_count_o + 32'd1;
      if (imem_data_i[31:26] == HALT_OP) begin
        state    <= HALT;
        halted_o <= 1'b1;
      end
    end
  end

endmodule
